arf_err_stats: RTL and testbench

//  Hardware error-statistics collector sitting directly downstream of the paired ARF datapaths.
//  - Inputs per sample: approximate (variance) and accurate results for both filter outputs (ch0 = out_27, ch1 = out_28).
//  - Per channel, over a programmed number of samples, it accumulates:
//    - signed error sum (var - acc)
//    - error-squared sum
//    - sum of |acc|
//  - Host-side software derives mean/std/MSE/SNR from these. Replaces per-sample software bookkeeping on long runs.

---
 rtl/arf_err_stats.sv | 224 ++++++++++++++++++++++
 tb/tb_arf_err_stats.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arf_err_stats.sv
// rtl/arf_err_stats.sv - per-channel error statistics (error sum, error-squared sum, |acc| sum)
// collected over a programmed number of samples through a 3-stage saturating pipeline.
module arf_err_stats #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int ACC_W  = 64,
  parameter int SQ_W   = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] var_0,
  input  logic [DATA_W-1:0] acc_0,
  input  logic [DATA_W-1:0] var_1,
  input  logic [DATA_W-1:0] acc_1,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  err_sum_0,
  output logic [ACC_W-1:0]  err_sum_1,
  output logic [SQ_W-1:0]   sq_sum_0,
  output logic [SQ_W-1:0]   sq_sum_1,
  output logic [ACC_W-1:0]  abs_sum_0,
  output logic [ACC_W-1:0]  abs_sum_1,
  output logic              sat_0,
  output logic              sat_1
);

  localparam int EW = DATA_W + 1;
  localparam int PW = 2 * DATA_W + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic              done_q, done_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [EW-1:0]     s1_err_q [2];
  logic [EW-1:0]     s1_err_d [2];
  logic [EW-1:0]     s1_abs_q [2];
  logic [EW-1:0]     s1_abs_d [2];
  logic [EW-1:0]     s2_err_q [2];
  logic [EW-1:0]     s2_err_d [2];
  logic [EW-1:0]     s2_abs_q [2];
  logic [EW-1:0]     s2_abs_d [2];
  logic [PW-1:0]     s2_sq_q  [2];
  logic [PW-1:0]     s2_sq_d  [2];
  logic [ACC_W-1:0]  err_sum_q [2];
  logic [ACC_W-1:0]  err_sum_d [2];
  logic [ACC_W-1:0]  abs_sum_q [2];
  logic [ACC_W-1:0]  abs_sum_d [2];
  logic [SQ_W-1:0]   sq_sum_q  [2];
  logic [SQ_W-1:0]   sq_sum_d  [2];
  logic [1:0]        sat_q, sat_d;

  logic [DATA_W-1:0] var_in [2];
  logic [DATA_W-1:0] acc_in [2];
  logic [PW-1:0]     err_x  [2];
  logic [ACC_W:0]    es_w   [2];
  logic [SQ_W:0]     ss_w   [2];
  logic [ACC_W:0]    as_w   [2];
  logic              start_acc, xfer, last_xfer;

  assign var_in[0] = var_0;
  assign var_in[1] = var_1;
  assign acc_in[0] = acc_0;
  assign acc_in[1] = acc_1;

  always_comb begin
    start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    xfer      = in_valid && (state_q == ST_ACCUM);
    last_xfer = xfer && (cnt_q == (num_q - CNT_W'(1)));
  end

  // Next-state logic; DRAIN ends on the edge where the final sample leaves S2.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) state_d = (num_samples == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (last_xfer) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    busy      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    done      = done_q;
    err_sum_0 = err_sum_q[0];
    err_sum_1 = err_sum_q[1];
    sq_sum_0  = sq_sum_q[0];
    sq_sum_1  = sq_sum_q[1];
    abs_sum_0 = abs_sum_q[0];
    abs_sum_1 = abs_sum_q[1];
    sat_0     = sat_q[0];
    sat_1     = sat_q[1];
  end

  always_comb begin
    done_d = (state_d == ST_DONE) && ((state_q != ST_DONE) || start_acc);
    cnt_d  = cnt_q;
    num_d  = num_q;
    if (start_acc) begin
      cnt_d = '0;
      num_d = num_samples;
    end else if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // S1/S2: widened difference and magnitude are exact, so the square never overflows PW.
  always_comb begin
    s1_valid_d = xfer;
    s2_valid_d = s1_valid_q;
    for (int i = 0; i < 2; i++) begin
      s1_err_d[i] = s1_err_q[i];
      s1_abs_d[i] = s1_abs_q[i];
      s2_err_d[i] = s2_err_q[i];
      s2_abs_d[i] = s2_abs_q[i];
      s2_sq_d[i]  = s2_sq_q[i];
      err_x[i]    = {{(PW-EW){s1_err_q[i][EW-1]}}, s1_err_q[i]};
      if (xfer) begin
        s1_err_d[i] = {var_in[i][DATA_W-1], var_in[i]} - {acc_in[i][DATA_W-1], acc_in[i]};
        s1_abs_d[i] = acc_in[i][DATA_W-1] ? (~{1'b1, acc_in[i]} + EW'(1)) : {1'b0, acc_in[i]};
      end
      if (s1_valid_q) begin
        s2_err_d[i] = s1_err_q[i];
        s2_abs_d[i] = s1_abs_q[i];
        s2_sq_d[i]  = err_x[i] * err_x[i];
      end
    end
  end

  // S3: one guard bit per accumulator detects overflow; clamp instead of wrapping.
  always_comb begin
    sat_d = sat_q;
    for (int i = 0; i < 2; i++) begin
      err_sum_d[i] = err_sum_q[i];
      sq_sum_d[i]  = sq_sum_q[i];
      abs_sum_d[i] = abs_sum_q[i];
      es_w[i] = {err_sum_q[i][ACC_W-1], err_sum_q[i]}
              + {{(ACC_W+1-EW){s2_err_q[i][EW-1]}}, s2_err_q[i]};
      ss_w[i] = {1'b0, sq_sum_q[i]} + {{(SQ_W+1-PW){1'b0}}, s2_sq_q[i]};
      as_w[i] = {1'b0, abs_sum_q[i]} + {{(ACC_W+1-EW){1'b0}}, s2_abs_q[i]};
      if (start_acc) begin
        err_sum_d[i] = '0;
        sq_sum_d[i]  = '0;
        abs_sum_d[i] = '0;
        sat_d[i]     = 1'b0;
      end else if (s2_valid_q) begin
        if (es_w[i][ACC_W] != es_w[i][ACC_W-1]) begin
          err_sum_d[i] = es_w[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          sat_d[i]     = 1'b1;
        end else begin
          err_sum_d[i] = es_w[i][ACC_W-1:0];
        end
        if (ss_w[i][SQ_W]) begin
          sq_sum_d[i] = '1;
          sat_d[i]    = 1'b1;
        end else begin
          sq_sum_d[i] = ss_w[i][SQ_W-1:0];
        end
        if (as_w[i][ACC_W]) begin
          abs_sum_d[i] = '1;
          sat_d[i]     = 1'b1;
        end else begin
          abs_sum_d[i] = as_w[i][ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sat_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        s1_err_q[i]  <= '0;
        s1_abs_q[i]  <= '0;
        s2_err_q[i]  <= '0;
        s2_abs_q[i]  <= '0;
        s2_sq_q[i]   <= '0;
        err_sum_q[i] <= '0;
        sq_sum_q[i]  <= '0;
        abs_sum_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sat_q      <= sat_d;
      for (int i = 0; i < 2; i++) begin
        s1_err_q[i]  <= s1_err_d[i];
        s1_abs_q[i]  <= s1_abs_d[i];
        s2_err_q[i]  <= s2_err_d[i];
        s2_abs_q[i]  <= s2_abs_d[i];
        s2_sq_q[i]   <= s2_sq_d[i];
        err_sum_q[i] <= err_sum_d[i];
        sq_sum_q[i]  <= sq_sum_d[i];
        abs_sum_q[i] <= abs_sum_d[i];
      end
    end
  end

endmodule

// File: tb/tb_arf_err_stats.sv
// tb/tb_arf_err_stats.sv - bench for arf_err_stats: known-answer table, corner sequences,
// randomized runs against an arithmetic reference model.
module tb_arf_err_stats;

  localparam int DW = 32;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int SW = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] var_0 = '0, acc_0 = '0, var_1 = '0, acc_1 = '0;
  logic          busy, done, sat_0, sat_1;
  logic [AW-1:0] err_sum_0, err_sum_1, abs_sum_0, abs_sum_1;
  logic [SW-1:0] sq_sum_0, sq_sum_1;

  arf_err_stats #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW), .SQ_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .var_0(var_0), .acc_0(acc_0), .var_1(var_1), .acc_1(acc_1),
    .busy(busy), .done(done),
    .err_sum_0(err_sum_0), .err_sum_1(err_sum_1),
    .sq_sum_0(sq_sum_0), .sq_sum_1(sq_sum_1),
    .abs_sum_0(abs_sum_0), .abs_sum_1(abs_sum_1),
    .sat_0(sat_0), .sat_1(sat_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] qv0[$], qa0[$], qv1[$], qa1[$];

  typedef struct {
    logic [63:0] e;
    logic [95:0] s;
    logic [63:0] b;
    logic        sat;
  } res_t;

  typedef struct {
    logic [31:0] v0, a0, v1, a1;
    logic [63:0] e0;
    logic [95:0] s0;
    logic [63:0] b0;
    logic [63:0] e1;
    logic [95:0] s1;
    logic [63:0] b1;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: exact sums over the first n stimulus samples, then clamp to the output ranges.
  function automatic res_t model_ch(input int n, input int ch);
    logic signed [127:0] se, ss, sb, v, a, d, maxe, mine;
    res_t r;
    se = 0; ss = 0; sb = 0;
    maxe = (128'sd1 <<< 63) - 128'sd1;
    mine = -(128'sd1 <<< 63);
    for (int k = 0; k < n; k++) begin
      v = $signed(ch == 0 ? qv0[k] : qv1[k]);
      a = $signed(ch == 0 ? qa0[k] : qa1[k]);
      d = v - a;
      se = se + d;
      ss = ss + d * d;
      sb = sb + ((a < 0) ? -a : a);
    end
    r.sat = 1'b0;
    if (se > maxe) begin r.e = 64'h7fff_ffff_ffff_ffff; r.sat = 1'b1; end
    else if (se < mine) begin r.e = 64'h8000_0000_0000_0000; r.sat = 1'b1; end
    else r.e = se[63:0];
    if (ss >= (128'sd1 <<< 96)) begin r.s = '1; r.sat = 1'b1; end
    else r.s = ss[95:0];
    if (sb >= (128'sd1 <<< 64)) begin r.b = '1; r.sat = 1'b1; end
    else r.b = sb[63:0];
    return r;
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h7fff_ffff;
      1: return 32'h8000_0000;
      2: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic fill_rand(input int cnt);
    qv0 = {}; qa0 = {}; qv1 = {}; qa1 = {};
    for (int k = 0; k < cnt; k++) begin
      qv0.push_back(rnd()); qa0.push_back(rnd());
      qv1.push_back(rnd()); qa1.push_back(rnd());
    end
  endtask

  task automatic check_results(input string nm, input res_t r0, input res_t r1);
    chk({nm, " err_sum_0"}, 128'(err_sum_0), 128'(r0.e));
    chk({nm, " sq_sum_0"},  128'(sq_sum_0),  128'(r0.s));
    chk({nm, " abs_sum_0"}, 128'(abs_sum_0), 128'(r0.b));
    chk({nm, " sat_0"},     128'(sat_0),     128'(r0.sat));
    chk({nm, " err_sum_1"}, 128'(err_sum_1), 128'(r1.e));
    chk({nm, " sq_sum_1"},  128'(sq_sum_1),  128'(r1.s));
    chk({nm, " abs_sum_1"}, 128'(abs_sum_1), 128'(r1.b));
    chk({nm, " sat_1"},     128'(sat_1),     128'(r1.sat));
  endtask

  // One run: offers queue samples (valid optionally toggled), counts handshakes, checks done timing
  // and results. next_n >= 0 holds start high after the last sample so the next run begins on done.
  task automatic run_check(input string nm, input int n, input bit throttle, input bit restart_mid,
                           input bit pre_started, input int next_n);
    int idx, xfers, last_x, done_cyc, start_cyc, budget, k, exp_lat, ref_cyc;
    bit hs;
    res_t r0, r1;
    idx = 0; xfers = 0; last_x = -1; done_cyc = -1; budget = 0;
    r0 = model_ch(n, 0);
    r1 = model_ch(n, 1);
    if (pre_started) begin
      start_cyc = cyc - 1;
      start = 1'b0;
    end else begin
      start = 1'b1;
      num_samples = n;
      in_valid = 1'b0;
      @(negedge clk);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (done_cyc < 0 && budget < 300) begin
      k = (idx < qv0.size()) ? idx : qv0.size() - 1;
      in_valid = !throttle || (budget % 2 == 0);
      var_0 = qv0[k]; acc_0 = qa0[k]; var_1 = qv1[k]; acc_1 = qa1[k];
      if (next_n >= 0 && idx >= n) begin
        start = 1'b1; num_samples = next_n;
      end else if (restart_mid && budget == 3) begin
        start = 1'b1; num_samples = 3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs) begin xfers++; last_x = cyc; end
      if (done) begin
        done_cyc = cyc;
        check_results(nm, r0, r1);
        chk({nm, " busy at done"}, 128'(busy), 128'(0));
        chk({nm, " in_ready at done"}, 128'(in_ready), 128'(0));
      end
      @(posedge clk); #1;
      if (hs) idx++;
      budget++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk({nm, " done seen"}, 128'(done_cyc >= 0), 128'(1));
    chk({nm, " transfers"}, 128'(xfers), 128'(n));
    exp_lat = (n == 0) ? 1 : 3;
    ref_cyc = (n == 0) ? start_cyc : last_x;
    chk({nm, " done latency"}, 128'(done_cyc - ref_cyc), 128'(exp_lat));
    if (next_n < 0) begin
      @(negedge clk);
      chk({nm, " done one cycle"}, 128'(done), 128'(0));
      chk({nm, " hold err_sum_0"}, 128'(err_sum_0), 128'(r0.e));
      chk({nm, " hold sq_sum_1"}, 128'(sq_sum_1), 128'(r1.s));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0] = '{32'd10, 32'd7, 32'hFFFF_FFFB, 32'd2,
               64'd3, 96'd9, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 96'd49, 64'd2};
    tbl[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
               64'd4294967295, 96'd18446744065119617025, 64'd2147483648,
               64'hFFFF_FFFF_0000_0001, 96'd18446744065119617025, 64'd2147483647};
    tbl[2] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF,
               64'd0, 96'd0, 64'd0, 64'd1, 96'd1, 64'd1};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9,
               64'd0, 96'd0, 64'd2147483648, 64'd14, 96'd196, 64'd7};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset err_sum_0", 128'(err_sum_0), 128'(0));
    chk("reset sq_sum_1", 128'(sq_sum_1), 128'(0));
    chk("reset sat", 128'({sat_1, sat_0}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Known-answer table, N=1 per record (extra queue entries are offered but must be dropped)
    for (int i = 0; i < 4; i++) begin
      fill_rand(4);
      qv0[0] = tbl[i].v0; qa0[0] = tbl[i].a0; qv1[0] = tbl[i].v1; qa1[0] = tbl[i].a1;
      run_check($sformatf("tbl%0d", i), 1, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk);
      chk($sformatf("tbl%0d const err0", i), 128'(err_sum_0), 128'(tbl[i].e0));
      chk($sformatf("tbl%0d const sq0", i),  128'(sq_sum_0),  128'(tbl[i].s0));
      chk($sformatf("tbl%0d const abs0", i), 128'(abs_sum_0), 128'(tbl[i].b0));
      chk($sformatf("tbl%0d const err1", i), 128'(err_sum_1), 128'(tbl[i].e1));
      chk($sformatf("tbl%0d const sq1", i),  128'(sq_sum_1),  128'(tbl[i].s1));
      chk($sformatf("tbl%0d const abs1", i), 128'(abs_sum_1), 128'(tbl[i].b1));
      chk($sformatf("tbl%0d const sat", i),  128'({sat_1, sat_0}), 128'(0));
    end

    // N=4 hand example on ch0
    fill_rand(8);
    qv0[0] = 32'd10;  qa0[0] = 32'd7;
    qv0[1] = 32'd5;   qa0[1] = 32'd8;
    qv0[2] = 32'hFFFF_FFFD; qa0[2] = 32'hFFFF_FFFD;
    qv0[3] = 32'd100; qa0[3] = 32'hFFFF_FFCE;
    run_check("n4", 4, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("n4 const err0", 128'(err_sum_0), 128'(150));
    chk("n4 const sq0", 128'(sq_sum_0), 128'(22518));
    chk("n4 const abs0", 128'(abs_sum_0), 128'(68));

    // num_samples == 0
    fill_rand(3);
    run_check("n0", 0, 1'b0, 1'b0, 1'b0, -1);

    // Throttled valid with an ignored start during ACCUM
    fill_rand(12);
    run_check("throttle", 8, 1'b1, 1'b1, 1'b0, -1);

    // Back-to-back: start held through DRAIN, accepted on the done cycle
    fill_rand(6);
    run_check("b2b_a", 2, 1'b0, 1'b0, 1'b0, 2);
    fill_rand(6);
    run_check("b2b_b", 2, 1'b0, 1'b0, 1'b1, -1);

    // Asynchronous reset mid-run
    fill_rand(12);
    start = 1'b1; num_samples = 10; in_valid = 1'b1;
    var_0 = 32'd5; acc_0 = 32'd1; var_1 = 32'd9; acc_1 = 32'hFFFF_FFF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid in_ready", 128'(in_ready), 128'(0));
    chk("rst_mid busy", 128'(busy), 128'(0));
    chk("rst_mid err_sum_0", 128'(err_sum_0), 128'(0));
    chk("rst_mid abs_sum_1", 128'(abs_sum_1), 128'(0));
    chk("rst_mid sq_sum_0", 128'(sq_sum_0), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst idle in_ready", 128'(in_ready), 128'(0));
    chk("post_rst done", 128'(done), 128'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int n;
      bit th;
      n  = $urandom_range(1, 12);
      th = 1'($urandom_range(0, 1));
      fill_rand(n + 4);
      run_check($sformatf("rand%0d", r), n, th, 1'b0, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
